traffic_ctrl_timed: RTL and testbench

//  Two-road (NS main / EW side) traffic light controller. Successor of the single-sensor Mealy controller.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/traffic_phase_timer.sv | 29 ++
 rtl/traffic_ctrl_timed.sv | 123 ++++++++++++
 tb/tb_traffic_ctrl_timed.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - lamp encodings, controller states and lamp decode
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2,
    OFF    = 2'd3
  } light_e;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED2  = 3'd5,
    FLASH     = 3'd6
  } state_e;

  // Returns {ns_lamp, ew_lamp}; phase only matters while flashing.
  function automatic logic [3:0] lamps(state_e s, logic phase);
    case (s)
      NS_GREEN:  lamps = {GREEN, RED};
      NS_YELLOW: lamps = {YELLOW, RED};
      EW_GREEN:  lamps = {RED, GREEN};
      EW_YELLOW: lamps = {RED, YELLOW};
      FLASH:     lamps = phase ? {OFF, OFF} : {YELLOW, RED};
      default:   lamps = {RED, RED};
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// rtl/traffic_phase_timer.sv - phase cycle counter with clear and terminal compare
module traffic_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  // Saturates so a long-held NS green never falls back below its minimum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (count_q != {CNT_W{1'b1}}) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
  assign done  = (count_q == term);

endmodule

// File: rtl/traffic_ctrl_timed.sv
// rtl/traffic_ctrl_timed.sv - timed two-road light controller with ped request and flash mode
module traffic_ctrl_timed
  import traffic_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int MIN_GREEN_NS = 8,
  parameter int YELLOW_T     = 3,
  parameter int ALL_RED_T    = 2,
  parameter int MIN_GREEN_EW = 4,
  parameter int MAX_GREEN_EW = 10,
  parameter int FLASH_T      = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       X,
  input  logic       ped_btn,
  input  logic       flash,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       ped_walk
);

  localparam logic [CNT_W-1:0] T_NS_MIN = CNT_W'(MIN_GREEN_NS - 1);
  localparam logic [CNT_W-1:0] T_YEL    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] T_RED    = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] T_EW_MIN = CNT_W'(MIN_GREEN_EW - 1);
  localparam logic [CNT_W-1:0] T_EW_MAX = CNT_W'(MAX_GREEN_EW - 1);
  localparam logic [CNT_W-1:0] T_FLASH  = CNT_W'(FLASH_T - 1);

  state_e           state_q, state_d;
  logic             ped_req_q, ped_req_d;
  logic             walk_q, walk_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] timer_q, term;
  logic             timer_done, timer_clr, enter_ew;

  traffic_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (timer_clr),
    .term  (term),
    .count (timer_q),
    .done  (timer_done)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    term      = '0;
    timer_clr = 1'b0;
    case (state_q)
      NS_GREEN: begin
        term = T_NS_MIN;
        if (timer_q >= T_NS_MIN && (X || ped_req_q)) state_d = NS_YELLOW;
      end
      NS_YELLOW: begin
        term = T_YEL;
        if (timer_done) state_d = ALL_RED1;
      end
      ALL_RED1: begin
        term = T_RED;
        if (timer_done) state_d = EW_GREEN;
      end
      EW_GREEN: begin
        term = T_EW_MAX;
        if ((timer_q >= T_EW_MIN && !X && !walk_q) || timer_done) state_d = EW_YELLOW;
      end
      EW_YELLOW: begin
        term = T_YEL;
        if (timer_done) state_d = ALL_RED2;
      end
      ALL_RED2: begin
        term = T_RED;
        if (timer_done) state_d = NS_GREEN;
      end
      FLASH: begin
        term = T_FLASH;
        if (timer_done) begin
          phase_d   = ~phase_q;
          timer_clr = 1'b1;
        end
        if (!flash) state_d = ALL_RED2;
      end
      default: state_d = ALL_RED2;
    endcase

    // Flash overrides every other exit; a fresh entry always starts in phase 0.
    if (flash) begin
      state_d = FLASH;
      if (state_q != FLASH) phase_d = 1'b0;
    end
    if (state_d != state_q) timer_clr = 1'b1;

    enter_ew = (state_d == EW_GREEN) && (state_q != EW_GREEN);
    if (flash)         ped_req_d = 1'b0;
    else if (ped_btn)  ped_req_d = 1'b1;
    else if (enter_ew) ped_req_d = 1'b0;
    else               ped_req_d = ped_req_q;

    if (state_d == EW_GREEN) walk_d = enter_ew ? ped_req_q : walk_q;
    else                     walk_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= NS_GREEN;
      ped_req_q <= 1'b0;
      walk_q    <= 1'b0;
      phase_q   <= 1'b0;
      ns_light  <= GREEN;
      ew_light  <= RED;
      ped_walk  <= 1'b0;
    end else begin
      state_q                <= state_d;
      ped_req_q              <= ped_req_d;
      walk_q                 <= walk_d;
      phase_q                <= phase_d;
      {ns_light, ew_light}   <= lamps(state_d, phase_d);
      ped_walk               <= walk_d;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
// tb/tb_traffic_ctrl_timed.sv - directed self-checking bench for traffic_ctrl_timed
module tb_traffic_ctrl_timed;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       X = 1'b0;
  logic       ped_btn = 1'b0;
  logic       flash = 1'b0;
  logic [1:0] ns_light, ew_light;
  logic       ped_walk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  localparam logic [3:0] GR = 4'b1000;
  localparam logic [3:0] YR = 4'b0100;
  localparam logic [3:0] RR = 4'b0000;
  localparam logic [3:0] RG = 4'b0010;
  localparam logic [3:0] RY = 4'b0001;
  localparam logic [3:0] OO = 4'b1111;

  traffic_ctrl_timed dut (
    .clock    (clock),
    .reset    (reset),
    .X        (X),
    .ped_btn  (ped_btn),
    .flash    (flash),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .ped_walk (ped_walk)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Timeline of one full cycle: ny = edge entering NS_YELLOW, ewy = edge entering EW_YELLOW.
  function automatic logic [3:0] exp_lamps(int n, int ny, int ewy);
    if (n < ny)           return GR;
    if (n < ny + 3)       return YR;
    if (n < ny + 5)       return RR;
    if (n < ewy)          return RG;
    if (n < ewy + 3)      return RY;
    if (n < ewy + 5)      return RR;
    return GR;
  endfunction

  task automatic tick();
    @(posedge clock);
    edge_n++;
    @(negedge clock);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    X = 1'b0;
    ped_btn = 1'b0;
    flash = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    edge_n = 0;
    check({tag, "_rst_lamps"}, {4'b0, ns_light, ew_light}, {4'b0, GR});
    check({tag, "_rst_walk"}, {7'b0, ped_walk}, 8'd0);
  endtask

  task automatic run_to(input int last, input int ny, input int ewy,
                        input int ws, input int we, input string tag);
    while (edge_n < last) begin
      tick();
      check($sformatf("%s_lamps_e%0d", tag, edge_n), {4'b0, ns_light, ew_light},
            {4'b0, exp_lamps(edge_n, ny, ewy)});
      check($sformatf("%s_walk_e%0d", tag, edge_n), {7'b0, ped_walk},
            {7'b0, (edge_n >= ws && edge_n <= we)});
    end
  endtask

  initial begin
    // X held: max EW green, then async reset in EW_YELLOW
    apply_reset("xheld");
    X = 1'b1;
    run_to(24, 8, 23, -1, -1, "xheld");
    #2 reset = 1'b1;
    #1;
    check("xheld_async_lamps", {4'b0, ns_light, ew_light}, {4'b0, GR});
    check("xheld_async_walk", {7'b0, ped_walk}, 8'd0);

    // X pulse edges 2..15: EW green ends at min once X drops
    apply_reset("xpulse");
    run_to(1, 8, 17, -1, -1, "xpulse");
    X = 1'b1;
    run_to(15, 8, 17, -1, -1, "xpulse");
    X = 1'b0;
    run_to(22, 8, 17, -1, -1, "xpulse");

    // X drops before NS minimum with no ped request: request cancelled
    apply_reset("xdrop");
    run_to(1, 1000, 1000, -1, -1, "xdrop");
    X = 1'b1;
    run_to(5, 1000, 1000, -1, -1, "xdrop");
    X = 1'b0;
    run_to(20, 1000, 1000, -1, -1, "xdrop");

    // Pedestrian pulse at edge 20, then async reset while walking
    apply_reset("ped");
    run_to(19, 21, 36, 26, 35, "ped");
    ped_btn = 1'b1;
    run_to(20, 21, 36, 26, 35, "ped");
    ped_btn = 1'b0;
    run_to(30, 21, 36, 26, 35, "ped");
    #2 reset = 1'b1;
    #1;
    check("ped_async_lamps", {4'b0, ns_light, ew_light}, {4'b0, GR});
    check("ped_async_walk", {7'b0, ped_walk}, 8'd0);

    // Idle for 100 cycles: NS green holds
    apply_reset("idle");
    run_to(100, 1000, 1000, -1, -1, "idle");

    // Flash requested mid EW green, released after edge 29
    apply_reset("flash");
    X = 1'b1;
    run_to(15, 8, 23, -1, -1, "flash");
    flash = 1'b1;
    while (edge_n < 29) begin
      tick();
      check($sformatf("flash_lamps_e%0d", edge_n), {4'b0, ns_light, ew_light},
            {4'b0, ((((edge_n - 16) / 4) % 2) == 0) ? YR : OO});
      check($sformatf("flash_walk_e%0d", edge_n), {7'b0, ped_walk}, 8'd0);
    end
    flash = 1'b0;
    while (edge_n < 36) begin
      tick();
      check($sformatf("unflash_lamps_e%0d", edge_n), {4'b0, ns_light, ew_light},
            {4'b0, (edge_n < 32) ? RR : GR});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
